yadmc_arbiter: RTL
==================

Name: yadmc_arbiter

Overview:
- Shares the single DRAM command channel of the memory controller between NPORTS requesters, using round-robin arbitration.
- Owns the periodic auto-refresh schedule. Refresh is issued to the command sequencer through a req/ack handshake and takes priority over new grants.
- Sits between the bus-side port front-ends and the DRAM command sequencer.
- All signals are in one clock domain. Any cross-domain flags are synchronised before they reach this block.

Parameters:
- NPORTS, 4: number of requesters, range 2..8.
- REFRESH_CYCLES, 740: sys_clk cycles between refresh deadlines, minimum 16.
- CNT_W, 10: refresh counter width; requires 2^CNT_W > REFRESH_CYCLES.

Ports:
- sys_clk  in  1  clock, all logic on rising edge.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- req  in  NPORTS  per-port request; held high for the whole transaction.
- grant  out  NPORTS  one-hot grant, registered.
- refresh_req  out  1  refresh request to the sequencer, registered.
- refresh_ack  in  1  single-cycle pulse: refresh completed.
- refresh_overrun  out  1  sticky error flag: a deadline expired while the previous refresh was still pending.
- idle  out  1  high when state is IDLE and no refresh is pending.

Behaviour:
- Reset (async assert, sync deassert use) sets:
  - grant=0, refresh_req=0, refresh_overrun=0
  - state=IDLE, pending=0
  - last pointer=NPORTS-1, so port 0 has first priority
  - refresh counter=REFRESH_CYCLES-1
- Refresh counter:
  - Decrements every cycle, whatever the state.
  - At 0: reloads REFRESH_CYCLES-1 and sets pending the next cycle. The first deadline is therefore REFRESH_CYCLES cycles after reset release.
  - If pending is already 1 when the counter hits 0, refresh_overrun is set and pending stays 1. Only one refresh is owed.
- FSM states: IDLE, GRANT, REFRESH.
- IDLE:
  - If pending: go to REFRESH; refresh_req=1 on the next cycle. Refresh beats requests.
  - Else, if any req: select the first requester found scanning from last+1 upward, wrapping modulo NPORTS. Next cycle: grant=onehot(sel), last=sel, state GRANT. Latency from req to grant is 1 cycle.
  - Else: stay in IDLE.
- GRANT:
  - grant is held while req[owner]=1. Other requests are ignored and pending does not pre-empt.
  - When req[owner]=0, grant=0 on the next cycle and state returns to IDLE.
  - There is at least one IDLE cycle between consecutive grants.
- REFRESH:
  - refresh_req is held at 1 until refresh_ack is sampled high.
  - On the next cycle: refresh_req=0, state IDLE, pending cleared.
  - If the counter hits 0 in the same cycle as the ack, pending stays 1 (the new deadline wins) and refresh_overrun is not set.
- refresh_ack outside REFRESH is ignored.
- req for an ungranted port can drop at any time without effect.
- grant is never multi-hot, and grant and refresh_req are never both high.
- Reset mid-transaction or mid-refresh forces all outputs to their reset values immediately. No ack is expected afterwards.
- idle = (state==IDLE) && !pending; it is combinational from registers.

Test Plan:
- Priority after reset: release reset with req=4'b0110 → grant=4'b0010 one cycle later. Drop req[1] → grant=0 next cycle. The next grant is 4'b0100.
- Round-robin fairness: hold req=4'b1111 and have each owner release after 3 cycles → grant sequence 0001, 0010, 0100, 1000, 0001, with one idle cycle between each.
- Refresh timing, REFRESH_CYCLES=20, no req: refresh_req rises at cycle 21 after reset release. Ack 5 cycles later → refresh_req falls the next cycle and idle=1.
- Refresh versus owner: port 2 holds the grant across the refresh deadline → no refresh_req while the grant is held. After port 2 releases: state IDLE, then refresh_req=1 one cycle later, even though req[0]=1 is waiting. Port 0 is granted only after the ack.
- Overrun: withhold refresh_ack for more than 20 cycles → refresh_overrun=1 and stays 1 after the ack. Assert sys_rst_n=0 mid-refresh → refresh_req=0 and refresh_overrun=0 immediately.
- Ack/deadline collision: ack in the same cycle the counter hits 0 → pending stays set, a second refresh_req follows one IDLE cycle later, and refresh_overrun=0.

Source files
------------

// File: rtl/yadmc_arbiter.sv
// Round-robin arbiter for the DRAM command channel. It also owns the
// periodic auto-refresh schedule, and refresh takes priority over new grants.
module yadmc_arbiter #(
  parameter int NPORTS         = 4,
  parameter int REFRESH_CYCLES = 740,
  parameter int CNT_W          = 10
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [NPORTS-1:0] req,
  output logic [NPORTS-1:0] grant,
  output logic              refresh_req,
  input  logic              refresh_ack,
  output logic              refresh_overrun,
  output logic              idle
);

  localparam int LW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, REFRESH} state_t;

  state_t           state;
  logic [LW-1:0]    last;
  logic [LW-1:0]    sel;
  logic [CNT_W-1:0] cnt;
  logic             pending;
  logic             deadline;
  logic             ack_taken;

  assign deadline  = (cnt == '0);
  assign ack_taken = (state == REFRESH) && refresh_ack;
  assign idle      = (state == IDLE) && !pending;

  // Scan from the port after the last owner, wrapping, so every requester
  // is reached within NPORTS grants.
  always_comb begin
    logic [LW-1:0] idx;
    logic          found;
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    sel   = last;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NPORTS; i++) begin
      idx = LW'((int'(last) + i) % NPORTS);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // branch below sees the values from before this clock edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state           <= IDLE;
      grant           <= '0;
      refresh_req     <= 1'b0;
      refresh_overrun <= 1'b0;
      pending         <= 1'b0;
      last            <= LW'(NPORTS - 1);
      cnt             <= CNT_W'(REFRESH_CYCLES - 1);
    end else begin
      cnt <= deadline ? CNT_W'(REFRESH_CYCLES - 1) : cnt - CNT_W'(1);

      // Only one refresh is ever owed. A deadline that coincides with the
      // ack re-arms pending and is not counted as an overrun.
      if (deadline) begin
        pending <= 1'b1;
        if (pending && !ack_taken) refresh_overrun <= 1'b1;
      end else if (ack_taken) begin
        pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pending) begin
            state       <= REFRESH;
            refresh_req <= 1'b1;
          end else if (|req) begin
            state <= GRANT;
            grant <= NPORTS'(1) << sel;
            last  <= sel;
          end
        end
        GRANT: begin
          if (!req[last]) begin
            grant <= '0;
            state <= IDLE;
          end
        end
        REFRESH: begin
          if (refresh_ack) begin
            refresh_req <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
